// File: rtl/mem_stage_sram_ctrl_pkg.sv
// mem_stage_sram_ctrl_pkg: shared state encoding and sizing helpers for the MEM-stage SRAM controllers
package mem_stage_sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int BEATS = 32 / 16;
  localparam int BEAT_IDX_W = idx_w(BEATS);
  localparam int TO_CNT_W = $clog2(15 + 1);
endpackage

// File: rtl/mem_stage_sram_ctrl_beat_counter.sv
// mem_stage_sram_ctrl_beat_counter: beat index and per-beat ack timeout counter
module mem_stage_sram_ctrl_beat_counter
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int BEATS_N = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       inc,
  input  logic                       tick,
  output logic [idx_w(BEATS_N)-1:0]  beat,
  output logic                       last,
  output logic                       to_term
);
  localparam int IDX_W = idx_w(BEATS_N);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDX_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] to_q, to_d;
  always_comb begin
    beat_d = clear ? '0 : inc ? beat_q + 1'b1 : beat_q;
    to_d = (clear | inc) ? '0 : tick ? to_q + 1'b1 : to_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      to_q <= '0;
    end else begin
      beat_q <= beat_d;
      to_q <= to_d;
    end
  end
  assign beat = beat_q;
  assign last = beat_q == IDX_W'(BEATS_N - 1);
  assign to_term = to_q == CNT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: splits pipeline word loads/stores into narrow SRAM beats, freezing the pipeline meanwhile
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH = 16,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_BASE = 1024,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Sig_Memory_Read_Enable,
  input  logic                  i_Sig_Memory_Write_Enable,
  input  logic [DATA_WIDTH-1:0] i_Address,
  input  logic [DATA_WIDTH-1:0] i_Write_Data,
  output logic                  o_Freeze,
  output logic                  o_Ready,
  output logic [DATA_WIDTH-1:0] o_Read_Data,
  output logic                  o_Error,
  output logic [ADDR_WIDTH-1:0] o_Sram_Address,
  output logic [BUS_WIDTH-1:0]  o_Sram_Write_Data,
  output logic                  o_Sram_Read_Enable,
  output logic                  o_Sram_Write_Enable,
  input  logic [BUS_WIDTH-1:0]  i_Sram_Read_Data,
  input  logic                  i_Sram_Ack
);
  localparam int BEATS_N = DATA_WIDTH / BUS_WIDTH;
  localparam int IDX_W = idx_w(BEATS_N);
  localparam int SH = $clog2(DATA_WIDTH / 8);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, asm_q, asm_d, rd_q, rd_d;
  logic re_q, re_d, we_q, we_d, err_q, err_d;
  logic [IDX_W-1:0] beat;
  logic last, to_term, act, hs, wait_tick, req;
  assign req = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;
  assign act = re_q | we_q;
  assign hs = act & i_Sram_Ack;
  assign wait_tick = act & ~i_Sram_Ack;
  mem_stage_sram_ctrl_beat_counter #(
    .BEATS_N(BEATS_N),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_cnt (
    .clk(clk),
    .rst(reset),
    .clear(state_q == IDLE),
    .inc(hs),
    .tick(wait_tick),
    .beat(beat),
    .last(last),
    .to_term(to_term)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    asm_d = asm_q;
    rd_d = rd_q;
    re_d = re_q;
    we_d = we_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = BEAT;
        addr_d = i_Address;
        wdata_d = i_Write_Data;
        we_d = i_Sig_Memory_Write_Enable;
        re_d = ~i_Sig_Memory_Write_Enable;
      end
      BEAT: begin
        if (hs & re_q) asm_d[beat*BUS_WIDTH +: BUS_WIDTH] = i_Sram_Read_Data;
        // finish on last acked beat or on timeout; a timed-out load returns zero
        if ((hs & last) | (wait_tick & to_term)) begin
          state_d = DONE;
          re_d = 1'b0;
          we_d = 1'b0;
          err_d = err_q | ~hs;
          if (re_q) rd_d = hs ? asm_d : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      asm_q <= '0;
      rd_q <= '0;
      re_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      asm_q <= asm_d;
      rd_q <= rd_d;
      re_q <= re_d;
      we_q <= we_d;
      err_q <= err_d;
    end
  end
  assign o_Freeze = ~reset & (state_q == IDLE ? req : state_q == BEAT);
  assign o_Ready = state_q == DONE;
  assign o_Read_Data = rd_q;
  assign o_Error = err_q;
  assign o_Sram_Read_Enable = re_q;
  assign o_Sram_Write_Enable = we_q;
  assign o_Sram_Address = act ? ADDR_WIDTH'(((addr_q - DATA_WIDTH'(MEM_BASE)) >> SH) * DATA_WIDTH'(BEATS_N) + DATA_WIDTH'(beat)) : '0;
  assign o_Sram_Write_Data = we_q ? wdata_q[beat*BUS_WIDTH +: BUS_WIDTH] : '0;
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: scoreboard bench with an SRAM responder model and a 32-bit-bus build
module tb_mem_stage_sram_ctrl;
  logic clk = 0, rst = 1;
  logic i_re = 0, i_we = 0;
  logic [31:0] i_a = 0, i_wd = 0;
  logic o_fz, o_rdy, o_err, o_re, o_we;
  logic [31:0] o_rd;
  logic [17:0] o_addr;
  logic [15:0] o_swd, i_srd = 0;
  logic i_ack = 0;
  logic b_ren = 0;
  logic [31:0] b_a = 0;
  logic b_fz, b_rdy, b_err, b_re, b_we, b_ack;
  logic [31:0] b_rd, b_swd, b_srd;
  logic [17:0] b_addr;
  int checks = 0, failures = 0, cyc = 0;
  int ack_delay = 0, wcnt = 0;
  logic no_ack = 0, spur = 0;
  logic [15:0] mem [16];
  typedef struct {logic [31:0] rd; logic err; int cyc;} exp_t;
  typedef struct {logic [17:0] a; logic w; logic [15:0] d;} beat_t;
  exp_t exp_q[$];
  beat_t bq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_stage_sram_ctrl dut (
    .clk(clk), .reset(rst),
    .i_Sig_Memory_Read_Enable(i_re), .i_Sig_Memory_Write_Enable(i_we),
    .i_Address(i_a), .i_Write_Data(i_wd),
    .o_Freeze(o_fz), .o_Ready(o_rdy), .o_Read_Data(o_rd), .o_Error(o_err),
    .o_Sram_Address(o_addr), .o_Sram_Write_Data(o_swd),
    .o_Sram_Read_Enable(o_re), .o_Sram_Write_Enable(o_we),
    .i_Sram_Read_Data(i_srd), .i_Sram_Ack(i_ack)
  );

  mem_stage_sram_ctrl #(.DATA_WIDTH(32), .BUS_WIDTH(32)) dut32 (
    .clk(clk), .reset(rst),
    .i_Sig_Memory_Read_Enable(b_ren), .i_Sig_Memory_Write_Enable(1'b0),
    .i_Address(b_a), .i_Write_Data(32'h0),
    .o_Freeze(b_fz), .o_Ready(b_rdy), .o_Read_Data(b_rd), .o_Error(b_err),
    .o_Sram_Address(b_addr), .o_Sram_Write_Data(b_swd),
    .o_Sram_Read_Enable(b_re), .o_Sram_Write_Enable(b_we),
    .i_Sram_Read_Data(b_srd), .i_Sram_Ack(b_ack)
  );
  assign b_ack = b_re | b_we;
  assign b_srd = (b_addr == 18'd1) ? 32'hA5A5_0001 : 32'h0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic exp_beat(input logic [17:0] a, input logic w, input logic [15:0] d);
    bq.push_back('{a, w, d});
  endtask

  // SRAM model: acks after ack_delay wait cycles, checks each beat against the expected queue
  always @(negedge clk) begin
    if (o_re | o_we) begin
      if (!no_ack && wcnt == ack_delay) begin
        i_ack = 1;
        wcnt = 0;
        if (bq.size() == 0) chk("unexpected_beat", {14'h0, o_addr}, 32'hFFFF_FFFF);
        else begin
          beat_t b;
          b = bq.pop_front();
          chk("beat_addr", {14'h0, o_addr}, {14'h0, b.a});
          chk("beat_we", {31'h0, o_we}, {31'h0, b.w});
          if (b.w) chk("beat_wdata", {16'h0, o_swd}, {16'h0, b.d});
        end
        i_srd = mem[o_addr[3:0]];
        if (o_we) mem[o_addr[3:0]] = o_swd;
      end else begin
        i_ack = 0;
        wcnt++;
      end
    end else begin
      i_ack = spur;
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (o_rdy) begin
      if (exp_q.size() == 0) chk("unexpected_ready", 32'h1, 32'h0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("read_data", o_rd, e.rd);
        chk("error", {31'h0, o_err}, {31'h0, e.err});
        chk("ready_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input int d, input int lat, input logic [31:0] erd, input logic eerr);
    int fz;
    @(negedge clk);
    i_re = re; i_we = we; i_a = a; i_wd = wd; ack_delay = d;
    exp_q.push_back('{erd, eerr, cyc + lat});
    fz = 0;
    #1;
    for (int n = 0; n < 100 && !o_rdy; n++) begin
      if (o_fz) fz++;
      @(negedge clk);
      #1;
    end
    if (!o_rdy) chk("ready_wait", 32'h0, 32'h1);
    chk("freeze_cycles", fz, lat);
    chk("freeze_at_ready", {31'h0, o_fz}, 32'h0);
    i_re = 0; i_we = 0;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 16'h0;
    mem[4] = 16'hBEEF; mem[5] = 16'hDEAD; mem[6] = 16'h1111; mem[7] = 16'h2222;
    repeat (2) @(negedge clk);
    chk("rst_freeze", {31'h0, o_fz}, 32'h0);
    chk("rst_ready", {31'h0, o_rdy}, 32'h0);
    chk("rst_error", {31'h0, o_err}, 32'h0);
    chk("rst_rdata", o_rd, 32'h0);
    chk("rst_sram", {o_re, o_we, o_swd, o_addr}, 36'h0);
    rst = 0;
    exp_beat(18'd4, 0, 0); exp_beat(18'd5, 0, 0);
    run(1, 0, 32'd1032, 0, 0, 3, 32'hDEADBEEF, 0);
    exp_beat(18'd0, 1, 16'h5678); exp_beat(18'd1, 1, 16'h1234);
    run(0, 1, 32'd1024, 32'h12345678, 2, 7, 32'hDEADBEEF, 0);
    exp_beat(18'd0, 0, 0); exp_beat(18'd1, 0, 0);
    run(1, 0, 32'd1024, 0, 1, 5, 32'h12345678, 0);
    spur = 1;
    repeat (3) @(negedge clk);
    spur = 0;
    chk("spur_ack_ignored", {30'h0, o_re, o_we}, 32'h0);
    no_ack = 1;
    run(1, 0, 32'd1036, 0, 0, 16, 32'h0, 1);
    no_ack = 0;
    exp_beat(18'd4, 0, 0); exp_beat(18'd5, 0, 0);
    run(1, 0, 32'd1032, 0, 0, 3, 32'hDEADBEEF, 1);
    no_ack = 1;
    @(negedge clk);
    i_re = 1; i_a = 32'd1032;
    repeat (3) @(negedge clk);
    chk("mid_beat_req", {31'h0, o_re}, 32'h1);
    rst = 1; i_re = 0;
    @(negedge clk);
    chk("midrst_enables", {30'h0, o_re, o_we}, 32'h0);
    chk("midrst_freeze", {31'h0, o_fz}, 32'h0);
    chk("midrst_error", {31'h0, o_err}, 32'h0);
    chk("midrst_ready", {31'h0, o_rdy}, 32'h0);
    rst = 0; no_ack = 0;
    repeat (2) @(negedge clk);
    chk("postrst_idle", {30'h0, o_re, o_we}, 32'h0);
    exp_beat(18'd0, 0, 0); exp_beat(18'd1, 0, 0);
    run(1, 0, 32'd1024, 0, 0, 3, 32'h12345678, 0);
    i_re = 1; i_we = 1; i_a = 32'd1028; i_wd = 32'hCAFEF00D;
    #1;
    chk("done_no_freeze", {31'h0, o_fz}, 32'h0);
    exp_beat(18'd2, 1, 16'hF00D); exp_beat(18'd3, 1, 16'hCAFE);
    run(1, 1, 32'd1028, 32'hCAFEF00D, 0, 3, 32'h12345678, 0);
    exp_beat(18'd2, 0, 0); exp_beat(18'd3, 0, 0);
    run(1, 0, 32'd1028, 0, 0, 3, 32'hCAFEF00D, 0);
    @(negedge clk);
    b_ren = 1; b_a = 32'd1028;
    #1;
    chk("b32_freeze0", {31'h0, b_fz}, 32'h1);
    @(negedge clk);
    chk("b32_req", {31'h0, b_re}, 32'h1);
    chk("b32_addr", {14'h0, b_addr}, 32'h1);
    chk("b32_freeze1", {31'h0, b_fz}, 32'h1);
    @(negedge clk);
    b_ren = 0;
    chk("b32_ready", {31'h0, b_rdy}, 32'h1);
    chk("b32_rdata", b_rd, 32'hA5A50001);
    chk("b32_freeze2", {31'h0, b_fz}, 32'h0);
    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'h0);
    chk("beat_q_empty", bq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Parametrised successor to the single-cycle data-memory path of the 5-stage ARM pipeline.
- Sits in the MEM stage between the EXE/MEM stage register and an external SRAM with a narrow bus and variable latency.
- Splits each 32-bit word access into bus beats over a req/ack handshake.
- Drives a pipeline-wide freeze while an access is in flight; a timeout raises a sticky error.

Parameters:
DATA_WIDTH, 32, pipeline word width (address and data)
BUS_WIDTH, 16, SRAM data bus width; must divide DATA_WIDTH; BEATS = DATA_WIDTH/BUS_WIDTH
ADDR_WIDTH, 18, SRAM address width (beat-granular)
MEM_BASE, 1024, byte address mapped to SRAM beat address 0
TIMEOUT_CYCLES, 15, max cycles per beat awaiting ack before abort

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
i_Sig_Memory_Read_Enable  in  1  load request from EXE/MEM register
i_Sig_Memory_Write_Enable  in  1  store request from EXE/MEM register
i_Address  in  DATA_WIDTH  byte address (ALU result)
i_Write_Data  in  DATA_WIDTH  store data (Rm value)
o_Freeze  out  1  stall all upstream stage registers and PC
o_Ready  out  1  one-cycle pulse: access complete
o_Read_Data  out  DATA_WIDTH  assembled load data, valid when o_Ready
o_Error  out  1  sticky timeout flag
o_Sram_Address  out  ADDR_WIDTH  beat address
o_Sram_Write_Data  out  BUS_WIDTH  beat write data
o_Sram_Read_Enable  out  1  read request
o_Sram_Write_Enable  out  1  write request
i_Sram_Read_Data  in  BUS_WIDTH  beat read data, valid with ack
i_Sram_Ack  in  1  beat accepted/completed

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; beat counter, timeout counter and data register cleared. Reset mid-access aborts immediately; no further SRAM requests.
- FSM states: IDLE, BEAT, DONE.
- IDLE:
  - o_Freeze = req, where req = read_en | write_en (combinational).
  - On req: latch address, write data and op; go to BEAT with beat=0.
  - Both enables high: treated as write.
- BEAT:
  - o_Freeze=1. Exactly one of o_Sram_Read_Enable / o_Sram_Write_Enable is high, registered.
  - o_Sram_Address = ((addr - MEM_BASE) >> log2(DATA_WIDTH/8)) * BEATS + beat, truncated to ADDR_WIDTH.
  - Beat 0 carries the least-significant BUS_WIDTH bits (little-endian).
  - Beat completes on a cycle with request & i_Sram_Ack. On a read, i_Sram_Read_Data is captured into slice [beat]. The timeout counter then clears and beat increments.
  - After the last beat: go to DONE and drop the request the next cycle.
  - Ack while no request is high is ignored.
- Timeout: the counter increments each BEAT cycle without ack. Reaching TIMEOUT_CYCLES sets o_Error (sticky until reset), drops the request and goes to DONE. In this case o_Read_Data = 0.
- DONE:
  - o_Freeze=0 and o_Ready=1 for exactly one cycle; o_Read_Data holds the assembled word.
  - The pipeline advances on this edge. Next state is IDLE.
  - No new request is accepted in DONE.
- Latency (zero-wait SRAM, ack in first request cycle): 1 + BEATS + 1 cycles. Freeze is high for the first 1+BEATS cycles.
- o_Read_Data holds its value until the next load completes.
- Stores: o_Read_Data unchanged.

Decomposition:
- Shared package: state encoding (IDLE/BEAT/DONE) and localparams BEATS, BEAT_IDX_W, TO_CNT_W.
- Sub-module beat_counter: beat index plus timeout counter, with inc/clear/terminal outputs. Natural to split and reuse for the future instruction-SRAM controller.

Test Plan:
- Load, BUS_WIDTH=16, i_Address=1032, ack every request cycle, data 0xBEEF then 0xDEAD -> addresses 4,5; o_Read_Data=0xDEADBEEF; o_Ready on cycle 3; freeze cycles 0-2.
- Store 0x12345678 to 1024, ack delayed 2 cycles per beat -> beat0 writes 0x5678 @0, beat1 writes 0x1234 @1; total 7 cycles; o_Error=0.
- BUS_WIDTH=32 build, load from 1028 -> single beat at address 1; 3-cycle latency.
- No ack for 15 cycles -> request dropped; o_Error=1 and stays 1 across later good accesses; o_Read_Data=0.
- reset asserted mid-BEAT -> next cycle state IDLE; all SRAM enables, o_Freeze and o_Error 0.
- Back-to-back load then store with both enables high -> store executes; no request accepted in DONE cycle; second access starts in the following IDLE.
